// File: rtl/pipeline_stage_skid_pkg.sv
// rsc_pipe_pkg: shared RISC15 pipeline constants and the stage occupancy encoding
package rsc_pipe_pkg;
    localparam int RSC_IR_W = 16;
    localparam int RSC_DATA_W = 16;
    localparam logic [RSC_IR_W-1:0] RSC_NOP = 16'hF000;
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE = 2'd1,
        OCC_FULL = 2'd2
    } occ_e;
endpackage

// File: rtl/pipeline_stage_skid_if.sv
// pipeline_stage_skid_if: handshake bundle of one elastic pipeline stage
//   upstream   : in_valid, in_ready, in_ir, in_data, in_ctrl, flush
//   downstream : out_valid, out_ready, out_ir, out_data, out_ctrl, occupancy
//   slave is the stage side, master the surrounding pipeline / bench side
interface pipeline_stage_skid_if #(
    parameter int IR_W = 16,
    parameter int DATA_W = 16,
    parameter int CTRL_W = 1
);
    logic in_valid;
    logic in_ready;
    logic [IR_W-1:0] in_ir;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic flush;
    logic out_valid;
    logic out_ready;
    logic [IR_W-1:0] out_ir;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0] occupancy;
    modport slave (
        input in_valid, in_ir, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_ir, out_data, out_ctrl, occupancy
    );
    modport master (
        output in_valid, in_ir, in_data, in_ctrl, flush, out_ready,
        input in_ready, out_valid, out_ir, out_data, out_ctrl, occupancy
    );
endinterface

// File: rtl/pipeline_stage_skid_entry.sv
// stage_entry: one {valid, ir, data, ctrl} holding register
//   load_i loads d_*_i, bubble_i loads the NOP bubble (bubble wins), else hold
//   valid_o/ir_o/data_o/ctrl_o present the held entry
module stage_entry #(
    parameter int IR_W = 16,
    parameter int DATA_W = 16,
    parameter int CTRL_W = 1,
    parameter logic [IR_W-1:0] NOP_IR = 16'hF000,
    parameter logic [CTRL_W-1:0] CTRL_RST = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic bubble_i,
    input  logic d_valid_i,
    input  logic [IR_W-1:0] d_ir_i,
    input  logic [DATA_W-1:0] d_data_i,
    input  logic [CTRL_W-1:0] d_ctrl_i,
    output logic valid_o,
    output logic [IR_W-1:0] ir_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);
    logic valid_q, valid_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    always_comb begin
        valid_d = bubble_i ? 1'b0 : load_i ? d_valid_i : valid_q;
        ir_d = bubble_i ? NOP_IR : load_i ? d_ir_i : ir_q;
        data_d = bubble_i ? '0 : load_i ? d_data_i : data_q;
        ctrl_d = bubble_i ? CTRL_RST : load_i ? d_ctrl_i : ctrl_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ir_q <= NOP_IR;
            data_q <= '0;
            ctrl_q <= CTRL_RST;
        end else begin
            valid_q <= valid_d;
            ir_q <= ir_d;
            data_q <= data_d;
            ctrl_q <= ctrl_d;
        end
    end
    assign valid_o = valid_q;
    assign ir_o = ir_q;
    assign data_o = data_q;
    assign ctrl_o = ctrl_q;
endmodule

// File: rtl/pipeline_stage_skid.sv
// pipeline_stage_skid: elastic RISC15 pipeline register with 2-entry skid and flush-to-NOP
//   clk, reset : rising-edge clock, async active-high reset
//   bus        : slave side of pipeline_stage_skid_if (valid/ready in and out, flush, occupancy)
module pipeline_stage_skid
    import rsc_pipe_pkg::*;
#(
    parameter int IR_W = RSC_IR_W,
    parameter int DATA_W = RSC_DATA_W,
    parameter int CTRL_W = 1,
    parameter logic [IR_W-1:0] NOP_IR = RSC_NOP,
    parameter logic [CTRL_W-1:0] CTRL_RST = '1
) (
    input logic clk,
    input logic reset,
    pipeline_stage_skid_if.slave bus
);
    occ_e state_q, state_d;
    logic acc, pop;
    logic head_load, head_bubble, head_from_skid, skid_load, skid_bubble;
    logic head_valid, skid_valid;
    logic [IR_W-1:0] head_ir, skid_ir;
    logic [DATA_W-1:0] head_data, skid_data;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
    // in_ready decodes only the state flop, so no path from out_ready
    assign bus.in_ready = state_q != OCC_FULL;
    assign acc = bus.in_valid & bus.in_ready;
    assign pop = head_valid & bus.out_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= OCC_EMPTY;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        head_load = 1'b0;
        head_bubble = 1'b0;
        head_from_skid = 1'b0;
        skid_load = 1'b0;
        skid_bubble = 1'b0;
        if (bus.flush) begin
            // squash beats any accept/pop this cycle
            head_bubble = 1'b1;
            skid_bubble = 1'b1;
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    head_load = acc;
                    state_d = acc ? OCC_ONE : OCC_EMPTY;
                end
                OCC_ONE: begin
                    head_load = acc & pop;
                    skid_load = acc & !pop;
                    head_bubble = !acc & pop;
                    state_d = (acc & !pop) ? OCC_FULL : (!acc & pop) ? OCC_EMPTY : OCC_ONE;
                end
                default: begin
                    // skid moves up and leaves a bubble behind
                    head_load = pop;
                    head_from_skid = 1'b1;
                    skid_bubble = pop;
                    state_d = pop ? OCC_ONE : OCC_FULL;
                end
            endcase
        end
    end
    stage_entry #(.IR_W(IR_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_IR(NOP_IR), .CTRL_RST(CTRL_RST)) u_head (
        .clk(clk),
        .reset(reset),
        .load_i(head_load),
        .bubble_i(head_bubble),
        .d_valid_i(head_from_skid ? skid_valid : 1'b1),
        .d_ir_i(head_from_skid ? skid_ir : bus.in_ir),
        .d_data_i(head_from_skid ? skid_data : bus.in_data),
        .d_ctrl_i(head_from_skid ? skid_ctrl : bus.in_ctrl),
        .valid_o(head_valid),
        .ir_o(head_ir),
        .data_o(head_data),
        .ctrl_o(head_ctrl)
    );
    stage_entry #(.IR_W(IR_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_IR(NOP_IR), .CTRL_RST(CTRL_RST)) u_skid (
        .clk(clk),
        .reset(reset),
        .load_i(skid_load),
        .bubble_i(skid_bubble),
        .d_valid_i(1'b1),
        .d_ir_i(bus.in_ir),
        .d_data_i(bus.in_data),
        .d_ctrl_i(bus.in_ctrl),
        .valid_o(skid_valid),
        .ir_o(skid_ir),
        .data_o(skid_data),
        .ctrl_o(skid_ctrl)
    );
    assign bus.out_valid = head_valid;
    assign bus.out_ir = head_ir;
    assign bus.out_data = head_data;
    assign bus.out_ctrl = head_ctrl;
    assign bus.occupancy = state_q;
endmodule
